// File: rtl/mux4_rr_arbiter_if.sv
// Select/handshake bundle between the requesters and the round-robin mux-select arbiter.
// The master side drives requests and enable; the slave side (the arbiter) returns grant, mux selects and qualifiers.
interface mux4_rr_arbiter_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       valid;
    logic       timeout;

    modport master (
        output en,
        output req,
        input  gnt,
        input  s0,
        input  s1,
        input  valid,
        input  timeout
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output s0,
        output s1,
        output valid,
        output timeout
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the s1/s0 select of a shared 4:1 mux, with bounded bursts,
// a mandatory idle cycle between grants, and a registered valid qualifier.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux4_rr_arbiter_if.slave       arb
);
    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_MAX_C = CW'(HOLD_MAX);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    state_t          state_r, state_s;
    logic [1:0]      idx_r, idx_s;
    logic [1:0]      ptr_r, ptr_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [3:0]      gnt_r, gnt_s;
    logic [1:0]      sel_r, sel_s;
    logic            valid_r, valid_s;
    logic            timeout_r, timeout_s;
    logic [2:0]      pick_s;
    logic            release_s;

    // Returns {found, index} of the first set request scanning from start upward (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] req_v, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            cand = start + 2'(k);
            if (req_v[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state and next-output decode for the IDLE/GRANT controller.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        gnt_s     = gnt_r;
        sel_s     = sel_r;
        valid_s   = valid_r;
        timeout_s = 1'b0;
        pick_s    = rr_pick(arb.req, ptr_r);
        release_s = (arb.req[idx_r] == 1'b0) || (arb.en == 1'b0) || (cnt_r == HOLD_MAX_C);
        case (state_r)
            ST_IDLE: begin
                if (arb.en && pick_s[2]) begin
                    idx_s   = pick_s[1:0];
                    gnt_s   = 4'b0001 << pick_s[1:0];
                    sel_s   = pick_s[1:0];
                    valid_s = 1'b1;
                    cnt_s   = CW'(1);
                    state_s = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    gnt_s     = 4'b0000;
                    valid_s   = 1'b0;
                    ptr_s     = idx_r + 2'd1;
                    state_s   = ST_IDLE;
                    // Only a forced release of a still-active, still-enabled requester counts as timeout.
                    timeout_s = (cnt_r == HOLD_MAX_C) && arb.req[idx_r] && arb.en;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 4'b0000;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous reset clears every output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= 2'd0;
            ptr_r     <= 2'd0;
            cnt_r     <= '0;
            gnt_r     <= 4'b0000;
            sel_r     <= 2'b00;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            ptr_r     <= ptr_s;
            cnt_r     <= cnt_s;
            gnt_r     <= gnt_s;
            sel_r     <= sel_s;
            valid_r   <= valid_s;
            timeout_r <= timeout_s;
        end
    end

    assign arb.gnt     = gnt_r;
    assign arb.s0      = sel_r[0];
    assign arb.s1      = sel_r[1];
    assign arb.valid   = valid_r;
    assign arb.timeout = timeout_r;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (HOLD_MAX 8 and 1) share stimulus and are
// compared every cycle against a per-instance behavioural model of the round-robin rules.
module tb_mux4_rr_arbiter;
    logic       clk;
    logic       rst_n;
    logic       en_s;
    logic [3:0] req_s;

    int n_cmp;
    int n_err;

    mux4_rr_arbiter_if bus8 ();
    mux4_rr_arbiter_if bus1 ();

    assign bus8.en  = en_s;
    assign bus8.req = req_s;
    assign bus1.en  = en_s;
    assign bus1.req = req_s;

    mux4_rr_arbiter #(.HOLD_MAX(8)) dut8 (.clk(clk), .rst_n(rst_n), .arb(bus8.slave));
    mux4_rr_arbiter #(.HOLD_MAX(1)) dut1 (.clk(clk), .rst_n(rst_n), .arb(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state per instance: owner (-1 = nobody), cycles used, priority start, last select.
    int hold  [2];
    int owner [2];
    int used  [2];
    int prio  [2];
    int sel   [2];
    bit tmo   [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            owner[i] = -1;
            used[i]  = 0;
            prio[i]  = 0;
            sel[i]   = 0;
            tmo[i]   = 1'b0;
        end
    endtask

    // One clock edge of the arbitration rules, applied to the inputs present at that edge.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            tmo[i] = 1'b0;
            if (owner[i] < 0) begin
                if (en_s && req_s != 4'b0000) begin
                    for (int off = 0; off < 4; off++) begin
                        if (owner[i] < 0 && req_s[(prio[i] + off) % 4]) begin
                            owner[i] = (prio[i] + off) % 4;
                        end
                    end
                    used[i] = 1;
                    sel[i]  = owner[i];
                end
            end else if (!req_s[owner[i]] || !en_s || used[i] == hold[i]) begin
                tmo[i]   = (used[i] == hold[i]) && req_s[owner[i]] && en_s;
                prio[i]  = (owner[i] + 1) % 4;
                owner[i] = -1;
            end else begin
                used[i] = used[i] + 1;
            end
        end
    endtask

    task automatic check_outputs(input string phase);
        logic [3:0] g [2];
        logic [1:0] s [2];
        logic       v [2];
        logic       t [2];
        g[0] = bus8.gnt; s[0] = {bus8.s1, bus8.s0}; v[0] = bus8.valid; t[0] = bus8.timeout;
        g[1] = bus1.gnt; s[1] = {bus1.s1, bus1.s0}; v[1] = bus1.valid; t[1] = bus1.timeout;
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("%s_h%0d_gnt", phase, hold[i]), 32'(g[i]),
                      (owner[i] < 0) ? 32'd0 : (32'd1 << owner[i]));
            check_val($sformatf("%s_h%0d_sel", phase, hold[i]), 32'(s[i]), 32'(sel[i]));
            check_val($sformatf("%s_h%0d_valid", phase, hold[i]), 32'(v[i]), 32'(owner[i] >= 0));
            check_val($sformatf("%s_h%0d_timeout", phase, hold[i]), 32'(t[i]), 32'(tmo[i]));
        end
    endtask

    task automatic step(input string phase);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check_outputs(phase);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        hold[0] = 8;
        hold[1] = 1;
        rst_n   = 1'b0;
        en_s    = 1'b0;
        req_s   = 4'b0000;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester held: 8-cycle bursts with timeout and one gap.
        req_s = 4'b0001;
        en_s  = 1'b1;
        step("single");
        check_val("single_first_gnt", 32'(bus8.gnt), 32'h1);
        check_val("single_first_valid", 32'(bus8.valid), 32'h1);
        for (int k = 0; k < 7; k++) step("single");
        step("single");
        check_val("single_timeout", 32'(bus8.timeout), 32'h1);
        check_val("single_gap_valid", 32'(bus8.valid), 32'h0);
        step("single");
        check_val("single_regrant", 32'(bus8.gnt), 32'h1);
        check_val("single_pulse_end", 32'(bus8.timeout), 32'h0);

        // All four requesting: rotation across requesters.
        req_s = 4'b1111;
        for (int k = 0; k < 50; k++) step("all4");

        // HOLD_MAX=1 pattern on two requesters.
        req_s = 4'b0101;
        for (int k = 0; k < 12; k++) step("pair");

        // en dropped for a while, then restored with two requesters.
        en_s = 1'b0;
        for (int k = 0; k < 4; k++) step("en_off");
        check_val("en_off_valid", 32'(bus8.valid), 32'h0);
        en_s  = 1'b1;
        req_s = 4'b0011;
        for (int k = 0; k < 10; k++) step("en_on");

        // Randomized stimulus: sticky requests so bursts and timeouts both occur.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0) req_s = 4'($urandom_range(0, 15));
            en_s = ($urandom_range(0, 11) != 0);
            step("rand");
        end

        // Asynchronous reset between edges in the middle of a grant.
        req_s = 4'b1111;
        en_s  = 1'b1;
        for (int k = 0; k < 3; k++) step("pre_rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        check_val("async_rst_gnt", 32'(bus8.gnt), 32'h0);
        step("in_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst");
        check_val("post_rst_gnt", 32'(bus8.gnt), 32'h1);
        for (int k = 0; k < 20; k++) step("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
